// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among N producers.
// Bursts are bounded, ffull stalls the grant, and fthreshold limits grants to high-priority producers.
//
// state | meaning
// IDLE  | no grant held; picks the next eligible requester after last_grant
// BUSY  | grant held by grant_id; data passes straight to the FIFO on handshake
module fifo_write_arbiter #(
  parameter int N = 4,
  parameter int DATA_W = 8,
  parameter int BURST_LEN = 4,
  parameter logic [N-1:0] HI_PRIO_MASK = N'(1),
  localparam int ID_W = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_valid,
  input  logic [N*DATA_W-1:0] req_data,
  output logic [N-1:0]        req_ready,
  input  logic                ffull,
  input  logic                fthreshold,
  output logic                fifo_wr,
  output logic [DATA_W-1:0]   fifo_wdata,
  output logic                grant_valid,
  output logic [ID_W-1:0]     grant_id
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     last_grant_q;
  logic [CNT_W-1:0]    beat_cnt_q;
  logic [N-1:0]        eligible;
  logic                sel_found;
  logic [ID_W-1:0]     sel_id;
  logic [ID_W-1:0]     idx;
  logic                g_valid, g_hi, g_ready;
  logic                transfer, last_beat, release_g;
  logic [DATA_W-1:0]   words [N];

  for (genvar i = 0; i < N; i++) begin : g_words
    assign words[i] = req_data[i*DATA_W +: DATA_W];
  end

  assign eligible = req_valid & ({N{~fthreshold}} | HI_PRIO_MASK);

  // Rotating scan starting just past the previous winner.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = ID_W'((32'(last_grant_q) + k) % N);
      if (!sel_found && eligible[idx]) begin
        sel_found = 1'b1;
        sel_id    = idx;
      end
    end
  end

  assign g_valid   = req_valid[grant_id];
  assign g_hi      = HI_PRIO_MASK[grant_id];
  assign g_ready   = (state_q == BUSY) & ~ffull & (~fthreshold | g_hi);
  assign transfer  = g_ready & g_valid;
  assign last_beat = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
  assign release_g = (transfer & last_beat) | ~g_valid | (fthreshold & ~g_hi);

  always_comb begin
    req_ready           = '0;
    req_ready[grant_id] = g_ready;
  end

  assign fifo_wr     = transfer;
  assign fifo_wdata  = transfer ? words[grant_id] : '0;
  assign grant_valid = (state_q == BUSY);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_found) state_d = BUSY;
      BUSY:    if (release_g) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_id     <= '0;
      last_grant_q <= ID_W'(N - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && sel_found) begin
        grant_id   <= sel_id;
        beat_cnt_q <= '0;
      end else if (state_q == BUSY) begin
        if (transfer) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
        if (release_g) last_grant_q <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: per-cycle observation of grant, ready and FIFO write
// compared against hand-computed vectors packed as {grant_valid, grant_id, fifo_wr, req_ready, fifo_wdata}.
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        ffull, fthreshold;
  logic        fifo_wr;
  logic [7:0]  fifo_wdata;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [15:0] obs;

  int n_checks = 0;
  int n_fail = 0;
  int word_cnt [4];
  int limit [4];
  logic [3:0] active;

  fifo_write_arbiter #(.N(4), .DATA_W(8), .BURST_LEN(4), .HI_PRIO_MASK(4'b0001)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .ffull(ffull), .fthreshold(fthreshold),
    .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  assign obs = {grant_valid, grant_id, fifo_wr, req_ready, fifo_wdata};

  // Producer i presents word {i, word_cnt[i]} while it has words left.
  task automatic apply_inputs();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = active[i] && (word_cnt[i] < limit[i]);
      req_data[i*8 +: 8] = {4'(i), 4'(word_cnt[i])};
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; active = '0; ffull = 1'b0; fthreshold = 1'b0;
    for (int i = 0; i < 4; i++) begin word_cnt[i] = 0; limit[i] = 1000; end
    apply_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; active = 4'b1111; ffull = 1'b0; fthreshold = 1'b0;
    for (int i = 0; i < 4; i++) begin word_cnt[i] = 0; limit[i] = 1000; end
    apply_inputs();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== 16'h0000) begin
        n_fail++; $display("FAIL reset cycle %0d: got %h expected 0000", c, obs);
      end
    end
  endtask

  task automatic test_single_burst();
    logic [15:0] exp [10] = '{16'h0000, 16'h9100, 16'h9101, 16'h9102, 16'h9103,
                              16'h0000, 16'h9104, 16'h9105, 16'h8100, 16'h0000};
    int writes = 0;
    apply_reset();
    active = 4'b0001; limit[0] = 6;
    for (int c = 0; c < 10; c++) begin
      apply_inputs();
      @(negedge clk);
      n_checks++;
      if (obs !== exp[c]) begin
        n_fail++; $display("FAIL single_burst cycle %0d: got %h expected %h", c, obs, exp[c]);
      end
      if (fifo_wr) writes++;
      if (exp[c][12]) word_cnt[exp[c][14:13]]++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (writes != 6) begin
      n_fail++; $display("FAIL single_burst_writes: got %0d expected 6", writes);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] e;
    int g, prev, writes;
    writes = 0;
    apply_reset();
    active = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      apply_inputs();
      g = (c / 5) % 4;
      prev = (c == 0) ? 0 : ((c / 5) + 3) % 4;
      if (c % 5 == 0) e = {1'b0, 2'(prev), 1'b0, 4'b0000, 8'h00};
      else            e = {1'b1, 2'(g), 1'b1, 4'(1 << g), 4'(g), 4'(word_cnt[g])};
      @(negedge clk);
      n_checks++;
      if (obs !== e) begin
        n_fail++; $display("FAIL round_robin cycle %0d: got %h expected %h", c, obs, e);
      end
      if (fifo_wr) writes++;
      if (e[12]) word_cnt[g]++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (writes != 20) begin
      n_fail++; $display("FAIL round_robin_writes: got %0d expected 20", writes);
    end
  endtask

  task automatic test_ffull_stall();
    logic [15:0] exp [9] = '{16'h0000, 16'hD420, 16'hC000, 16'hC000, 16'hC000,
                             16'hD421, 16'hD422, 16'hD423, 16'h4000};
    apply_reset();
    active = 4'b0100;
    for (int c = 0; c < 9; c++) begin
      ffull = (c >= 2 && c <= 4);
      apply_inputs();
      @(negedge clk);
      n_checks++;
      if (obs !== exp[c]) begin
        n_fail++; $display("FAIL ffull_stall cycle %0d: got %h expected %h", c, obs, exp[c]);
      end
      if (exp[c][12]) word_cnt[exp[c][14:13]]++;
      @(posedge clk); #1;
    end
    ffull = 1'b0;
  endtask

  task automatic test_threshold();
    logic [15:0] exp_a [6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h9100};
    logic [15:0] exp_b [5] = '{16'h0000, 16'hB210, 16'hA000, 16'h2000, 16'h2000};
    apply_reset();
    fthreshold = 1'b1;
    for (int c = 0; c < 6; c++) begin
      active = (c >= 4) ? 4'b1111 : 4'b1110;
      apply_inputs();
      @(negedge clk);
      n_checks++;
      if (obs !== exp_a[c]) begin
        n_fail++; $display("FAIL threshold_block cycle %0d: got %h expected %h", c, obs, exp_a[c]);
      end
      if (exp_a[c][12]) word_cnt[exp_a[c][14:13]]++;
      @(posedge clk); #1;
    end
    apply_reset();
    active = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      fthreshold = (c >= 2);
      apply_inputs();
      @(negedge clk);
      n_checks++;
      if (obs !== exp_b[c]) begin
        n_fail++; $display("FAIL threshold_release cycle %0d: got %h expected %h", c, obs, exp_b[c]);
      end
      if (exp_b[c][12]) word_cnt[exp_b[c][14:13]]++;
      @(posedge clk); #1;
    end
    fthreshold = 1'b0;
  endtask

  task automatic test_valid_drop();
    logic [15:0] exp [9] = '{16'h0000, 16'hB210, 16'hA200, 16'h2000, 16'hF830,
                             16'hF831, 16'hE800, 16'h6000, 16'h9100};
    apply_reset();
    active = 4'b1010; limit[1] = 1; limit[3] = 2;
    for (int c = 0; c < 9; c++) begin
      if (c == 6) active = 4'b1111;
      apply_inputs();
      @(negedge clk);
      n_checks++;
      if (obs !== exp[c]) begin
        n_fail++; $display("FAIL valid_drop cycle %0d: got %h expected %h", c, obs, exp[c]);
      end
      if (exp[c][12]) word_cnt[exp[c][14:13]]++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [15:0] exp [3] = '{16'h0000, 16'h9100, 16'h9101};
    apply_reset();
    active = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      apply_inputs();
      @(negedge clk);
      n_checks++;
      if (obs !== exp[c]) begin
        n_fail++; $display("FAIL reset_mid_burst cycle %0d: got %h expected %h", c, obs, exp[c]);
      end
      if (c < 2) begin
        if (exp[c][12]) word_cnt[exp[c][14:13]]++;
        @(posedge clk); #1;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 16'h0000) begin
      n_fail++; $display("FAIL reset_async: got %h expected 0000", obs);
    end
    @(posedge clk); #1;
    n_checks++;
    if (obs !== 16'h0000) begin
      n_fail++; $display("FAIL reset_held: got %h expected 0000", obs);
    end
    active = 4'b0101;
    apply_inputs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (obs !== 16'h9101) begin
      n_fail++; $display("FAIL reset_regrant: got %h expected 9101", obs);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_ffull_stall();
    test_threshold();
    test_valid_drop();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
